// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for a latency-1 FIFO: issues reads, buffers returned
// words in a 2-entry skid buffer and presents them as a valid/ready stream.
//
// state    | meaning
// IDLE     | no read issued last cycle
// STREAM   | read issued last cycle with more than one entry left
// THROTTLE | read issued last cycle with one entry or fewer left; skip a cycle
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  reset,
  input  logic                  f_empty,
  input  logic                  f_almost_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  enable_rd,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] STREAM   = 2'd1;
  localparam logic [1:0] THROTTLE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [1:0]            occ_q, occ_d;
  logic                  infl_q;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  pop;
  logic [2:0]            level;

  assign m_valid  = (occ_q != 2'd0);
  assign m_data   = buf0_q;
  assign rd_count = cnt_q;
  assign pop      = m_valid & m_ready;

  // Slots committed after this cycle; a new read needs one free slot left.
  assign level = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};

  assign enable_rd = !f_empty && (state_q != THROTTLE) && (level <= 3'd1) && !reset;

  always_comb begin
    state_d = IDLE;
    if (enable_rd) begin
      state_d = f_almost_empty ? THROTTLE : STREAM;
    end
  end

  // buf0 always holds the oldest entry; buf1 is only used when occ is 2.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;
    case ({infl_q, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = fifo_data;
        else               buf1_d = fifo_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = fifo_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      state_q <= IDLE;
      occ_q   <= 2'd0;
      infl_q  <= 1'b0;
      buf0_q  <= '0;
      buf1_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      infl_q  <= enable_rd;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      if (pop) cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: a behavioural latency-1 FIFO feeds the DUT,
// bytes loaded into it are queued as expected beats and checked as they pop.
module tb_fifo_rd_ctrl;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          rd_clk = 1'b0;
  logic          reset = 1'b1;
  logic          f_empty = 1'b1;
  logic          f_almost_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          m_ready = 1'b0;
  logic          enable_rd;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic [CW-1:0] rd_count;

  int n_vec = 0;
  int n_miss = 0;

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];

  logic [CW-1:0] exp_cnt = '0;
  logic          prev_stall = 1'b0;
  logic          prev_thr = 1'b0;
  logic [DW-1:0] prev_d = '0;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .rd_clk         (rd_clk),
    .reset          (reset),
    .f_empty        (f_empty),
    .f_almost_empty (f_almost_empty),
    .fifo_data      (fifo_data),
    .enable_rd      (enable_rd),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .rd_count       (rd_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic load(input logic [7:0] b);
    fq.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      if (exp_q.size() == 0 && fq.size() == 0 && !m_valid) done = 1'b1;
      else tick();
    end
    chk("drain_expected_left", exp_q.size(), 0);
    chk("drain_fifo_left", fq.size(), 0);
  endtask

  // Behavioural FIFO: data one cycle after the strobe, flags registered.
  always @(posedge rd_clk) begin
    if (enable_rd && fq.size() > 0) fifo_data <= fq.pop_front();
    f_empty        <= (fq.size() == 0);
    f_almost_empty <= (fq.size() <= 1);
  end

  // Monitor: beat order, counter, hold-under-stall, throttle gap, no read when empty.
  always @(negedge rd_clk) begin
    if (!reset) begin
      chk("rd_count", rd_count, exp_cnt);
      if (prev_stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, prev_d);
      end
      if (prev_thr) chk("throttle_gap", enable_rd, 0);
      if (f_empty) chk("read_when_empty", enable_rd, 0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_beat: got 0x%0h, expected no beat at %0t", m_data, $time);
        end else begin
          chk("m_data", m_data, exp_q.pop_front());
        end
        exp_cnt = exp_cnt + 1'b1;
      end
      prev_stall = m_valid && !m_ready;
      prev_thr   = enable_rd && f_almost_empty;
      prev_d     = m_data;
    end else begin
      exp_cnt    = '0;
      prev_stall = 1'b0;
      prev_thr   = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] en_pat;
    logic [7:0] v_pat;
    int reads;

    // Reset held two cycles with data waiting in the FIFO.
    load(8'h5A);
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge rd_clk);
      chk("rst_enable_rd", enable_rd, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_rd_count", rd_count, 0);
      chk("rst_m_data", m_data, 0);
      tick();
    end
    reset = 1'b0;
    m_ready = 1'b1;
    drain(20);

    // Streaming five bytes with the sink always ready.
    do_reset();
    load(8'h0A); load(8'h10); load(8'h41); load(8'h13); load(8'hAA);
    tick();
    en_pat = 8'b0001_1111;
    v_pat  = 8'b0111_1100;
    for (int i = 0; i < 8; i++) begin
      @(negedge rd_clk);
      chk("stream_enable_rd", enable_rd, en_pat[i]);
      chk("stream_m_valid", m_valid, v_pat[i]);
      tick();
    end
    drain(10);
    @(negedge rd_clk);
    chk("stream_rd_count", rd_count, 5);
    tick();

    // One-entry reads must leave a gap before the next read.
    do_reset();
    load(8'h77);
    tick();
    load(8'h88);
    en_pat = 8'b0000_0101;
    for (int i = 0; i < 4; i++) begin
      @(negedge rd_clk);
      chk("throttle_enable_rd", enable_rd, en_pat[i]);
      tick();
    end
    drain(10);

    // Backpressure: sink stalled for six cycles.
    do_reset();
    m_ready = 1'b0;
    load(8'h11); load(8'h22); load(8'h33); load(8'h44);
    tick();
    reads = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge rd_clk);
      if (enable_rd) reads++;
      tick();
    end
    @(negedge rd_clk);
    chk("bp_reads", reads, 2);
    chk("bp_m_valid", m_valid, 1);
    chk("bp_m_data", m_data, 8'h11);
    m_ready = 1'b1;
    drain(20);
    @(negedge rd_clk);
    chk("bp_rd_count", rd_count, 4);
    tick();

    // Empty FIFO: nothing read, nothing presented.
    for (int i = 0; i < 8; i++) begin
      @(negedge rd_clk);
      chk("empty_enable_rd", enable_rd, 0);
      chk("empty_m_valid", m_valid, 0);
      tick();
    end

    // Reset while one beat is buffered and one is returning.
    do_reset();
    m_ready = 1'b0;
    load(8'hA1); load(8'hA2); load(8'hA3); load(8'hA4);
    tick();
    tick();
    tick();
    reset = 1'b1;
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    @(negedge rd_clk);
    chk("midrst_enable_rd", enable_rd, 0);
    tick();
    reset = 1'b0;
    @(negedge rd_clk);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_rd_count", rd_count, 0);
    chk("midrst_m_data", m_data, 0);
    m_ready = 1'b1;
    tick();
    drain(20);
    @(negedge rd_clk);
    chk("midrst_final_count", rd_count, 2);
    tick();

    // Counter wrap with a 4-bit counter: 17 beats end at 1.
    do_reset();
    for (int i = 0; i < 17; i++) load(8'(i * 7 + 3));
    drain(60);
    @(negedge rd_clk);
    chk("wrap_rd_count", rd_count, 1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
